xy_output_arbiter: RTL and testbench

Round-robin, packet-locked arbiter for one output port of the simple mesh XY switch. It shares the output between the input-port FIFOs whose head packet is routed to it. It drives each FIFO's read enable and the registered data-mux select, and holds a grant from head flit to tail flit (wormhole). There is one instance per switch output port, between the input FIFOs/XY route logic and the output register.

---
 rtl/xy_output_arbiter_pkg.sv | 10 +
 rtl/xy_output_arbiter_rr_pick.sv | 24 ++
 rtl/xy_output_arbiter.sv | 60 ++++++
 tb/tb_xy_output_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/xy_output_arbiter_pkg.sv
// xy_output_arbiter_pkg: shared switch port indices, arbiter defaults and FSM state type
package xy_output_arbiter_pkg;
   localparam int PORT_N = 0;
   localparam int PORT_E = 1;
   localparam int PORT_S = 2;
   localparam int PORT_W = 3;
   localparam int PORT_L = 4;
   localparam int N_IN_DEFAULT = 5;
   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;
endpackage

// File: rtl/xy_output_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder picking the first request at or above ptr, wrapping mod N
module rr_pick #(
   parameter int N = 5,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx,
   output logic         any
);
   assign any = |req;
   always_comb begin
      int j;
      j = 0;
      idx = '0;
      // scan farthest offset first so the nearest requester from ptr wins
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k;
         if (req[j]) idx = j[W-1:0];
      end
      onehot = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/xy_output_arbiter.sv
// xy_output_arbiter: round-robin, packet-locked (wormhole) arbiter for one mesh switch output
module xy_output_arbiter
   import xy_output_arbiter_pkg::*;
#(
   parameter int N_IN = N_IN_DEFAULT,
   localparam int SEL_WIDTH = $clog2(N_IN)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [N_IN-1:0]      req_i,
   input  logic [N_IN-1:0]      tail_i,
   input  logic                 out_full_i,
   output logic [N_IN-1:0]      rd_en_o,
   output logic [N_IN-1:0]      grant_o,
   output logic [SEL_WIDTH-1:0] sel_o,
   output logic                 valid_o,
   output logic                 busy_o
);
   arb_state_e           state_q;
   logic [SEL_WIDTH-1:0] rr_ptr_q, g_q, pick_idx;
   logic [N_IN-1:0]      grant_q, pick_oh;
   logic                 pick_any, rd_any, tail_rd;

   rr_pick #(.N(N_IN)) u_pick (
      .req    (req_i),
      .ptr    (rr_ptr_q),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign rd_any  = (state_q == BUSY) & req_i[g_q] & ~out_full_i;
   assign rd_en_o = rd_any ? grant_q : '0;
   assign tail_rd = rd_any & tail_i[g_q];
   assign grant_o = grant_q;
   assign busy_o  = (state_q == BUSY);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         g_q      <= '0;
         grant_q  <= '0;
         sel_o    <= '0;
         valid_o  <= 1'b0;
      end else begin
         valid_o <= rd_any;
         if (rd_any) sel_o <= g_q;
         if (state_q == IDLE && pick_any) begin
            state_q <= BUSY;
            grant_q <= pick_oh;
            g_q     <= pick_idx;
         end else if (tail_rd) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= (g_q == SEL_WIDTH'(N_IN - 1)) ? '0 : g_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_xy_output_arbiter.sv
// tb_xy_output_arbiter: directed-vector self-checking bench for xy_output_arbiter (N_IN=5)
module tb_xy_output_arbiter;
   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [4:0] req_i = '0, tail_i = '0, rd_en_o, grant_o;
   logic       out_full_i = 1'b0, valid_o, busy_o;
   logic [2:0] sel_o;
   int         n_vec = 0, n_err = 0;

   xy_output_arbiter dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req_i),
      .tail_i     (tail_i),
      .out_full_i (out_full_i),
      .rd_en_o    (rd_en_o),
      .grant_o    (grant_o),
      .sel_o      (sel_o),
      .valid_o    (valid_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic outs(input string tag, input logic [4:0] rd, input logic [4:0] gr,
                       input logic bz, input logic vl, input logic [2:0] sl);
      chk({tag, ".rd_en"}, 32'(rd_en_o), 32'(rd));
      chk({tag, ".grant"}, 32'(grant_o), 32'(gr));
      chk({tag, ".busy"},  32'(busy_o),  32'(bz));
      chk({tag, ".valid"}, 32'(valid_o), 32'(vl));
      chk({tag, ".sel"},   32'(sel_o),   32'(sl));
   endtask

   task automatic cyc(input string tag, input logic [4:0] rq, input logic [4:0] tl, input logic fl,
                      input logic [4:0] rd, input logic [4:0] gr, input logic bz,
                      input logic vl, input logic [2:0] sl);
      @(negedge clk_i);
      req_i = rq;
      tail_i = tl;
      out_full_i = fl;
      #1 outs(tag, rd, gr, bz, vl, sl);
   endtask

   initial begin
      logic [2:0] order [6];
      logic [2:0] prev;
      order = '{3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
      @(negedge clk_i);
      #1 outs("reset", 5'b0, 5'b0, 0, 0, 3'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      // single 3-flit packet on input 2
      cyc("pkt_a", 5'b00100, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 3'd0);
      cyc("pkt_b", 5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 0, 3'd0);
      cyc("pkt_c", 5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 1, 3'd2);
      cyc("pkt_d", 5'b00100, 5'b00100, 0, 5'b00100, 5'b00100, 1, 1, 3'd2);
      cyc("pkt_e", 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 3'd2);
      cyc("pkt_f", 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 3'd2);
      // all requesting, 1-flit packets; pointer resumes at 3 after the first packet
      prev = 3'd2;
      for (int p = 0; p < 6; p++) begin
         cyc($sformatf("rr_bub%0d", p), 5'b11111, 5'b11111, 0, 5'b0, 5'b0, 0, p > 0, prev);
         cyc($sformatf("rr_gnt%0d", p), 5'b11111, 5'b11111, 0,
             5'b1 << order[p], 5'b1 << order[p], 1, 0, prev);
         prev = order[p];
      end
      // pointer now 4: input 4 first, then wrap to input 1
      cyc("wrap_a", 5'b10010, 5'b11111, 0, 5'b00000, 5'b00000, 0, 1, 3'd3);
      cyc("wrap_b", 5'b10010, 5'b11111, 0, 5'b10000, 5'b10000, 1, 0, 3'd3);
      cyc("wrap_c", 5'b10010, 5'b11111, 0, 5'b00000, 5'b00000, 0, 1, 3'd4);
      cyc("wrap_d", 5'b10010, 5'b11111, 0, 5'b00010, 5'b00010, 1, 0, 3'd4);
      cyc("wrap_e", 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 3'd1);
      // backpressure on input 0; a tail under full must not release
      cyc("bp_1", 5'b00001, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 3'd1);
      cyc("bp_2", 5'b00001, 5'b00000, 0, 5'b00001, 5'b00001, 1, 0, 3'd1);
      cyc("bp_3", 5'b00001, 5'b00001, 1, 5'b00000, 5'b00001, 1, 1, 3'd0);
      cyc("bp_4", 5'b00001, 5'b00001, 1, 5'b00000, 5'b00001, 1, 0, 3'd0);
      cyc("bp_5", 5'b00001, 5'b00001, 1, 5'b00000, 5'b00001, 1, 0, 3'd0);
      cyc("bp_6", 5'b00001, 5'b00001, 1, 5'b00000, 5'b00001, 1, 0, 3'd0);
      cyc("bp_7", 5'b00001, 5'b00000, 0, 5'b00001, 5'b00001, 1, 0, 3'd0);
      cyc("bp_8", 5'b00001, 5'b00001, 0, 5'b00001, 5'b00001, 1, 1, 3'd0);
      cyc("bp_9", 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 3'd0);
      // owner 2 drains mid-packet while input 3 requests
      cyc("drn_1", 5'b00100, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 3'd0);
      cyc("drn_2", 5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 0, 3'd0);
      cyc("drn_3", 5'b01000, 5'b01000, 0, 5'b00000, 5'b00100, 1, 1, 3'd2);
      cyc("drn_4", 5'b01000, 5'b01000, 0, 5'b00000, 5'b00100, 1, 0, 3'd2);
      cyc("drn_5", 5'b01100, 5'b00100, 0, 5'b00100, 5'b00100, 1, 0, 3'd2);
      cyc("drn_6", 5'b01000, 5'b01000, 0, 5'b00000, 5'b00000, 0, 1, 3'd2);
      cyc("drn_7", 5'b01000, 5'b01000, 0, 5'b01000, 5'b01000, 1, 0, 3'd2);
      cyc("drn_8", 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 1, 3'd3);
      // async reset mid-packet on input 2 (pointer 4 searches 4,0,1,2)
      cyc("ar_1", 5'b00100, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 3'd3);
      cyc("ar_2", 5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 0, 3'd3);
      cyc("ar_3", 5'b00100, 5'b00000, 0, 5'b00100, 5'b00100, 1, 1, 3'd2);
      #2 rst_ni = 1'b0;
      #1 outs("ar_in", 5'b00000, 5'b00000, 0, 0, 3'd0);
      @(posedge clk_i);
      #1 outs("ar_hold", 5'b00000, 5'b00000, 0, 0, 3'd0);
      #1 rst_ni = 1'b1;
      cyc("ar_4", 5'b00110, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 3'd0);
      cyc("ar_5", 5'b00110, 5'b00000, 0, 5'b00010, 5'b00010, 1, 0, 3'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
